// File: rtl/ram_bist_pkg.sv
// Shared types and defaults for the RAM BIST controller and its compare pipeline.
// The pattern helper works on 32-bit words; callers truncate to the RAM width.
package ram_bist_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WR_A  = 3'd1,
      RD_A  = 3'd2,
      WR_B  = 3'd3,
      RD_B  = 3'd4,
      DRAIN = 3'd5,
      DONE  = 3'd6
   } bist_state_e;

   localparam int         DEF_AW     = 4;
   localparam int         DEF_DW     = 8;
   localparam int         DEF_RD_LAT = 1;
   localparam int         DEF_ERRW   = 8;
   localparam logic [7:0] DEF_SEED   = 8'hA5;

   // Address-dependent pattern so stuck/shorted address lines show up as data errors.
   function automatic logic [31:0] bist_pat(input logic [31:0] addr,
                                            input logic [31:0] seed,
                                            input logic        invert);
      logic [31:0] p;
      p = seed ^ addr;
      return invert ? ~p : p;
   endfunction

endpackage

// File: rtl/ram_bist_chk.sv
// Read-compare pipeline: tracks issued reads for RD_LAT cycles and compares the
// returning RAM data, counting mismatches and latching the first failing address.
module ram_bist_chk
   import ram_bist_pkg::*;
#(
   parameter int AW     = DEF_AW,
   parameter int DW     = DEF_DW,
   parameter int RD_LAT = DEF_RD_LAT,
   parameter int ERRW   = DEF_ERRW
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            clr_i,
   input  logic            push_i,
   input  logic [AW-1:0]   push_addr_i,
   input  logic [DW-1:0]   push_exp_i,
   input  logic [DW-1:0]   ram_dout_i,
   output logic            mismatch_o,
   output logic [ERRW-1:0] err_count_o,
   output logic [AW-1:0]   fail_addr_o
);

   localparam logic [ERRW-1:0] ERR_MAX = '1;

   logic            v_q [RD_LAT];
   logic [AW-1:0]   a_q [RD_LAT];
   logic [DW-1:0]   e_q [RD_LAT];

   logic [ERRW-1:0] err_q, err_d;
   logic [AW-1:0]   fail_q, fail_d;
   logic            first_q, first_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < RD_LAT; i++) begin
            v_q[i] <= 1'b0;
            a_q[i] <= '0;
            e_q[i] <= '0;
         end
      end else begin
         v_q[0] <= push_i;
         a_q[0] <= push_addr_i;
         e_q[0] <= push_exp_i;
         for (int i = 1; i < RD_LAT; i++) begin
            v_q[i] <= v_q[i-1];
            a_q[i] <= a_q[i-1];
            e_q[i] <= e_q[i-1];
         end
      end
   end

   assign mismatch_o = v_q[RD_LAT-1] && (ram_dout_i != e_q[RD_LAT-1]);

   always_comb begin
      err_d   = err_q;
      fail_d  = fail_q;
      first_d = first_q;
      if (clr_i) begin
         err_d   = '0;
         fail_d  = '0;
         first_d = 1'b0;
      end else if (mismatch_o) begin
         if (err_q != ERR_MAX) begin
            err_d = err_q + ERRW'(1);
         end
         if (!first_q) begin
            fail_d = a_q[RD_LAT-1];
         end
         first_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         err_q   <= '0;
         fail_q  <= '0;
         first_q <= 1'b0;
      end else begin
         err_q   <= err_d;
         fail_q  <= fail_d;
         first_q <= first_d;
      end
   end

   assign err_count_o = err_q;
   assign fail_addr_o = fail_q;

endmodule

// File: rtl/ram_bist_ctrl.sv
// March-style BIST master for a single-port synchronous RAM: write/read a pattern,
// then its inverse, and report pass/fail, first failing address and error count.
module ram_bist_ctrl
   import ram_bist_pkg::*;
#(
   parameter int          AW     = DEF_AW,
   parameter int          DW     = DEF_DW,
   parameter int          RD_LAT = DEF_RD_LAT,
   parameter logic [DW-1:0] SEED = DW'(DEF_SEED),
   parameter int          ERRW   = DEF_ERRW
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   output logic            ram_we,
   output logic            ram_re,
   output logic [AW-1:0]   ram_addr,
   output logic [DW-1:0]   ram_din,
   input  logic [DW-1:0]   ram_dout,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [AW-1:0]   fail_addr,
   output logic [ERRW-1:0] err_count
);

   localparam int DEPTH = 2**AW;
   // Counter also times DRAIN, so it must hold RD_LAT-1 even for tiny RAMs.
   localparam int CW = (AW < 2) ? 2 : AW;
   localparam logic [CW-1:0] LAST_ADDR  = CW'(DEPTH - 1);
   localparam logic [CW-1:0] LAST_DRAIN = CW'(RD_LAT - 1);

   bist_state_e   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          run_start;
   logic          phase_last;

   logic          we_q, we_d;
   logic          re_q, re_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] din_q, din_d;
   logic          rd_inv_q, rd_inv_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          pass_q, pass_d;

   logic          mismatch;
   logic [DW-1:0] chk_exp;

   assign phase_last = (cnt_q == LAST_ADDR);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      run_start = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = WR_A;
               cnt_d     = '0;
               run_start = 1'b1;
            end
         end
         WR_A: begin
            cnt_d = phase_last ? '0 : cnt_q + CW'(1);
            if (phase_last) state_d = RD_A;
         end
         RD_A: begin
            cnt_d = phase_last ? '0 : cnt_q + CW'(1);
            if (phase_last) state_d = WR_B;
         end
         WR_B: begin
            cnt_d = phase_last ? '0 : cnt_q + CW'(1);
            if (phase_last) state_d = RD_B;
         end
         RD_B: begin
            cnt_d = phase_last ? '0 : cnt_q + CW'(1);
            if (phase_last) state_d = DRAIN;
         end
         DRAIN: begin
            if (cnt_q == LAST_DRAIN) begin
               state_d = DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are registered from the current state, so the RAM port runs one
   // cycle behind the FSM and busy rises the cycle after start is accepted.
   always_comb begin
      we_d     = (state_q == WR_A) || (state_q == WR_B);
      re_d     = (state_q == RD_A) || (state_q == RD_B);
      addr_d   = (we_d || re_d) ? AW'(cnt_q) : '0;
      din_d    = din_q;
      if (we_d) begin
         din_d = DW'(bist_pat(32'(cnt_q), 32'(SEED), state_q == WR_B));
      end
      rd_inv_d = (state_q == RD_B);
      busy_d   = (state_q != IDLE) && (state_q != DONE);
      done_d   = (state_q == DONE);
      pass_d   = pass_q;
      if (run_start) begin
         pass_d = 1'b0;
      end else if (state_q == DONE) begin
         // The final read may be compared on this same edge.
         pass_d = (err_count == '0) && !mismatch;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         we_q     <= 1'b0;
         re_q     <= 1'b0;
         addr_q   <= '0;
         din_q    <= '0;
         rd_inv_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         we_q     <= we_d;
         re_q     <= re_d;
         addr_q   <= addr_d;
         din_q    <= din_d;
         rd_inv_q <= rd_inv_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
      end
   end

   assign chk_exp = DW'(bist_pat(32'(addr_q), 32'(SEED), rd_inv_q));

   ram_bist_chk #(
      .AW     (AW),
      .DW     (DW),
      .RD_LAT (RD_LAT),
      .ERRW   (ERRW)
   ) u_chk (
      .clk         (clk),
      .reset       (reset),
      .clr_i       (run_start),
      .push_i      (re_q),
      .push_addr_i (addr_q),
      .push_exp_i  (chk_exp),
      .ram_dout_i  (ram_dout),
      .mismatch_o  (mismatch),
      .err_count_o (err_count),
      .fail_addr_o (fail_addr)
   );

   assign ram_we   = we_q;
   assign ram_re   = re_q;
   assign ram_addr = addr_q;
   assign ram_din  = din_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign pass     = pass_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: two instances (RD_LAT 1 and 2) with faulty-RAM models,
// a per-run expected-result scoreboard and a done-pulse monitor.
module tb_ram_bist_ctrl;

   localparam int NI = 2;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst     [NI];
   logic       start_s [NI];
   logic       we_s    [NI];
   logic       re_s    [NI];
   logic       busy_s  [NI];
   logic       done_s  [NI];
   logic       pass_s  [NI];
   logic [3:0] addr_s  [NI];
   logic [3:0] fail_s  [NI];
   logic [7:0] din_s   [NI];
   logic [7:0] dout_s  [NI];
   logic [7:0] err_s   [NI];
   logic [7:0] fmask   [NI][16];
   bit         both_seen [NI];

   int edge_n = 0;
   int checks = 0;
   int passes = 0;

   typedef struct {
      int done_edge;
      int pass;
      int err;
      int fail;
   } exp_t;

   exp_t sb [NI][$];

   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic chk(input string nm, input int act, input int exp_v);
      checks++;
      if (act == exp_v) passes++;
      else $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
   endtask

   // Reference: every location is read once per pattern; a read returns the
   // written pattern with the fault mask applied.
   function automatic exp_t ref_run(input int d, input int se);
      exp_t r;
      int   pat;
      r.err  = 0;
      r.fail = 0;
      for (int p = 0; p < 2; p++) begin
         for (int a = 0; a < 16; a++) begin
            pat = (8'hA5 ^ a) & 255;
            if (p == 1) pat = pat ^ 255;
            if ((pat & int'(fmask[d][a])) != pat) begin
               if (r.err == 0) r.fail = a;
               r.err = (r.err < 255) ? r.err + 1 : 255;
            end
         end
      end
      r.pass      = (r.err == 0) ? 1 : 0;
      r.done_edge = se + 4 * 16 + (d + 1) + 1;
      return r;
   endfunction

   generate
      for (genvar gi = 0; gi < NI; gi++) begin : g_inst
         logic [7:0] mem [16];
         logic [7:0] rp  [3];
         exp_t       e;

         ram_bist_ctrl #(
            .AW(4), .DW(8), .RD_LAT(gi + 1), .SEED(8'hA5), .ERRW(8)
         ) u_dut (
            .clk       (clk),
            .reset     (rst[gi]),
            .start     (start_s[gi]),
            .ram_we    (we_s[gi]),
            .ram_re    (re_s[gi]),
            .ram_addr  (addr_s[gi]),
            .ram_din   (din_s[gi]),
            .ram_dout  (dout_s[gi]),
            .busy      (busy_s[gi]),
            .done      (done_s[gi]),
            .pass      (pass_s[gi]),
            .fail_addr (fail_s[gi]),
            .err_count (err_s[gi])
         );

         always @(posedge clk) begin
            if (we_s[gi]) mem[addr_s[gi]] <= din_s[gi];
            if (re_s[gi]) rp[0] <= mem[addr_s[gi]] & fmask[gi][addr_s[gi]];
            rp[1] <= rp[0];
            rp[2] <= rp[1];
         end
         assign dout_s[gi] = rp[gi];

         always @(negedge clk) begin
            if (we_s[gi] && re_s[gi]) both_seen[gi] = 1'b1;
            if (done_s[gi]) begin
               chk($sformatf("u%0d_done_has_run", gi), int'(sb[gi].size() > 0), 1);
               if (sb[gi].size() > 0) begin
                  e = sb[gi].pop_front();
                  chk($sformatf("u%0d_done_edge", gi), edge_n, e.done_edge);
                  chk($sformatf("u%0d_pass", gi), int'(pass_s[gi]), e.pass);
                  chk($sformatf("u%0d_err_count", gi), int'(err_s[gi]), e.err);
                  chk($sformatf("u%0d_fail_addr", gi), int'(fail_s[gi]), e.fail);
                  $display("run u%0d done@%0d pass=%0d err=%0d fail_addr=%0d", gi, edge_n,
                           pass_s[gi], err_s[gi], fail_s[gi]);
               end
            end
         end
      end
   endgenerate

   // Call at a falling edge; start is sampled at edge tgt.
   task automatic pulse_start(input int d, input int tgt, input bit expect_run);
      while (edge_n < tgt - 1) @(negedge clk);
      start_s[d] = 1'b1;
      if (expect_run) sb[d].push_back(ref_run(d, tgt));
      @(negedge clk);
      start_s[d] = 1'b0;
   endtask

   task automatic wait_idle(input int d);
      int n;
      n = 0;
      while ((sb[d].size() != 0 || busy_s[d] || done_s[d]) && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("u%0d_idle_in_time", d), int'(n < 400), 1);
      @(negedge clk);
   endtask

   task automatic clear_masks();
      for (int d = 0; d < NI; d++)
         for (int a = 0; a < 16; a++) fmask[d][a] = 8'hFF;
   endtask

   task automatic run_one(input int d);
      pulse_start(d, edge_n + 1, 1'b1);
      wait_idle(d);
   endtask

   initial begin
      int se;
      int d;
      int nf;
      for (int i = 0; i < NI; i++) begin
         rst[i]       = 1'b1;
         start_s[i]   = 1'b0;
         both_seen[i] = 1'b0;
      end
      clear_masks();
      repeat (3) @(negedge clk);

      for (int i = 0; i < NI; i++) begin
         chk($sformatf("u%0d_rst_we", i), int'(we_s[i]), 0);
         chk($sformatf("u%0d_rst_re", i), int'(re_s[i]), 0);
         chk($sformatf("u%0d_rst_addr", i), int'(addr_s[i]), 0);
         chk($sformatf("u%0d_rst_din", i), int'(din_s[i]), 0);
         chk($sformatf("u%0d_rst_busy", i), int'(busy_s[i]), 0);
         chk($sformatf("u%0d_rst_done", i), int'(done_s[i]), 0);
         chk($sformatf("u%0d_rst_pass", i), int'(pass_s[i]), 0);
         chk($sformatf("u%0d_rst_fail", i), int'(fail_s[i]), 0);
         chk($sformatf("u%0d_rst_err", i), int'(err_s[i]), 0);
         rst[i] = 1'b0;
      end
      @(negedge clk);

      // Fault-free run with write-stream spot check
      se = edge_n + 1;
      pulse_start(0, se, 1'b1);
      chk("busy_low_at_accept", int'(busy_s[0]), 0);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk($sformatf("wr%0d_we", k), int'(we_s[0]), 1);
         chk($sformatf("wr%0d_addr", k), int'(addr_s[0]), k - 1);
         chk($sformatf("wr%0d_din", k), int'(din_s[0]), (8'hA5 ^ (k - 1)) & 255);
      end
      wait_idle(0);

      // Bit0 stuck at 0 at address 5
      fmask[0][5] = 8'hFE;
      run_one(0);
      clear_masks();

      // Address 3 and 9 read as zero
      fmask[0][3] = 8'h00;
      fmask[0][9] = 8'h00;
      run_one(0);
      clear_masks();

      // Reset mid-run at edge 30
      fmask[0][3] = 8'h00;
      se = edge_n + 1;
      pulse_start(0, se, 1'b0);
      while (edge_n < se + 29) @(negedge clk);
      chk("abort_busy_before", int'(busy_s[0]), 1);
      chk("abort_err_before", int'(err_s[0]), 1);
      rst[0] = 1'b1;
      @(negedge clk);
      rst[0] = 1'b0;
      chk("abort_busy", int'(busy_s[0]), 0);
      chk("abort_we", int'(we_s[0]), 0);
      chk("abort_re", int'(re_s[0]), 0);
      chk("abort_err", int'(err_s[0]), 0);
      chk("abort_done", int'(done_s[0]), 0);
      $display("abort u0 reset@%0d busy=%0d err=%0d", se + 30, busy_s[0], err_s[0]);
      repeat (80) @(negedge clk);
      clear_masks();
      run_one(0);

      // Starts during the run and in the DONE cycle are ignored
      se = edge_n + 1;
      pulse_start(0, se, 1'b1);
      pulse_start(0, se + 10, 1'b0);
      pulse_start(0, se + 66, 1'b0);
      pulse_start(0, se + 67, 1'b1);
      wait_idle(0);

      // Two-cycle read latency
      run_one(1);
      fmask[1][15] = 8'hFE;
      run_one(1);
      clear_masks();

      // Randomised fault sets
      for (int it = 0; it < 8; it++) begin
         d  = int'($urandom_range(0, 1));
         nf = int'($urandom_range(0, 3));
         for (int f = 0; f < nf; f++) fmask[d][$urandom_range(0, 15)] = 8'($urandom);
         run_one(d);
         clear_masks();
      end

      chk("u0_we_re_exclusive", int'(both_seen[0]), 0);
      chk("u1_we_re_exclusive", int'(both_seen[1]), 0);
      chk("u0_sb_drained", int'(sb[0].size()), 0);
      chk("u1_sb_drained", int'(sb[1].size()), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got edge %0d, expected finish before time limit", edge_n);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/ram_bist_ctrl.md
Name: ram_bist_ctrl

Overview:
- Built-in self-test initiator for the 16x8 single-port synchronous RAM. It is the master side of the RAM's clk/we/re/addr/din/dout interface.
- On a start pulse it writes a data pattern to every location and reads it back, then repeats with the inverted pattern.
- It compares every read word against the expected value and reports pass/fail, the first failing address and an error count.
- It sits beside the RAM and drives the RAM's port in place of the normal user logic while busy.

Parameters:
- AW, 4, RAM address width; DEPTH = 2**AW.
- DW, 8, RAM data width.
- RD_LAT, 1, RAM read latency in cycles: dout is valid RD_LAT cycles after the edge that samples re=1. Legal values are 1..3.
- SEED, 8'hA5, base data pattern.
- ERRW, 8, error counter width.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a test run.
- ram_we  out  1  RAM write enable.
- ram_re  out  1  RAM read enable.
- ram_addr  out  AW  RAM address.
- ram_din  out  DW  RAM write data.
- ram_dout  in  DW  RAM read data.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at the end of a run.
- pass  out  1  valid from done until the next accepted start; 1 means no mismatches.
- fail_addr  out  AW  address of the first mismatch in the run; 0 if none.
- err_count  out  ERRW  number of mismatching reads; saturates at all-ones.

Behaviour:
- Reset: state=IDLE. All outputs are 0: ram_we, ram_re, ram_addr, ram_din, busy, done, pass, fail_addr, err_count. The compare pipeline is flushed.
- Reset mid-run aborts the run immediately (same values as above) and does not pulse done.
- Patterns are registered outputs:
  - patA(a) = SEED XOR zero-extended a.
  - patB(a) = ~patA(a).
- States and transitions:
  - IDLE: start=1 moves to WR_A. Stats clear on that edge: err_count=0, fail_addr=0, pass=0, first-fail flag clear.
  - WR_A: we=1, re=0, addr counts 0→DEPTH-1, din=patA(addr). One address per cycle; at DEPTH-1 go to RD_A.
  - RD_A: we=0, re=1, addr 0→DEPTH-1, expected=patA(addr). At DEPTH-1 go to WR_B.
  - WR_B: as WR_A but with patB. Then go to RD_B.
  - RD_B: as RD_A but with patB. Then go to DRAIN.
  - DRAIN: we=re=0 for RD_LAT cycles so the last read can be compared. Then go to DONE.
  - DONE: done=1 for one cycle; busy=0; pass = (err_count==0). Return to IDLE.
- Address counter wraps to 0 at each phase change.
- While we=0, ram_din holds its last value.
- Compare pipeline:
  - Each issued read pushes {valid, addr, expected} into an RD_LAT-deep shift register.
  - When the tail is valid and ram_dout != expected, err_count increments (saturating).
  - On the first mismatch of a run, fail_addr captures the tail address.
  - Reads issued at the end of RD_A complete during WR_B; this is legal and must still be checked.
- Run length: 4*DEPTH + RD_LAT cycles busy.
  - With defaults: start sampled at edge 0, busy from edge 1, done at edge 66.
- Simultaneous events:
  - start while busy, or in the DONE cycle, is ignored.
  - reset has priority over start.
- ram_we and ram_re are never both 1.

Decomposition:
- ram_bist_pkg holds:
  - the state encoding: IDLE, WR_A, RD_A, WR_B, RD_B, DRAIN, DONE;
  - default AW, DW, SEED, RD_LAT constants;
  - a pattern function taking (addr, SEED, invert).
- One sub-module, ram_bist_chk: the RD_LAT-deep compare pipeline plus the err_count/fail_addr logic. Inputs are push valid, addr, expected and ram_dout; outputs are err_count and fail_addr.

Test Plan:
- Fault-free RAM model with defaults, start at cycle 0:
  - first four cycles: we=1, addr 0..3, din A5, A4, A7, A6;
  - done at edge 66, pass=1, err_count=0, fail_addr=0.
- RAM model forces dout bit0=0 when addr=5:
  - RD_A has no error, since patA(5)=A0;
  - RD_B: patB(5)=5F mismatches, giving pass=0, err_count=1, fail_addr=5.
- RAM model forces dout=00 at addr 3 and 9:
  - errors in both phases, so err_count=4;
  - fail_addr=3 (first fail only).
- reset asserted at edge 30 of a run:
  - next edge: busy=0, ram_we=ram_re=0, err_count=0;
  - no done pulse;
  - a new start then completes with pass=1.
- start re-pulsed at edges 10 and 66: both ignored, and only one done pulse occurs. A start at edge 67 begins a new run.
- RD_LAT=2 with a 2-cycle RAM model:
  - done at edge 67, pass=1;
  - an injected fault at addr 15 in RD_B still gives fail_addr=15, checked during DRAIN.
